// File: rtl/bin2bcd_pkg.sv
// Shared types, BCD weight table and nibble seeding helper for bin2bcd_seq.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // BCD value of 2**k for the bit positions the accumulator visits.
    localparam logic [15:0] BCD_W [4:9] = '{
        16'h0016, 16'h0032, 16'h0064, 16'h0128, 16'h0256, 16'h0512
    };

    // Low nibble (0..15) to BCD: tens is 0 or 1, ones is v mod 10.
    function automatic logic [15:0] nib2bcd(input logic [3:0] v);
        if (v >= 4'd10) begin
            return {12'h001, 4'(v - 4'd10)};
        end
        return {12'h000, v};
    endfunction

endpackage

// File: rtl/bcd_add_4dig.sv
// Combinational 4-digit BCD adder: sum = a + b, ripple carry across digits.
module bcd_add_4dig (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        carry_out
);

    // Per-digit add with decimal correction, carry rippling from ones upward.
    always_comb begin
        logic       c;
        logic [4:0] d;
        c   = 1'b0;
        d   = 5'd0;
        sum = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            if (d > 5'd9) begin
                d = d - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            sum[4*i +: 4] = d[3:0];
        end
        carry_out = c;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary -> 4-digit BCD converter, one operand bit per ACC cycle.
// Optional feature macro BIN2BCD_SKIP_ZERO_EN: ACC visits only the set bits
// of the operand above bit 3 (bcd results are identical either way).
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      bcd,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [BIN_W-1:4]   din_q, din_d;     // low nibble is consumed by the seed
    logic [3:0]         k_q, k_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [15:0]        add_b;
    logic [15:0]        add_sum;
    logic               carry_unused;     // cannot be set for BIN_W <= 10

`ifdef BIN2BCD_SKIP_ZERO_EN
    logic [4:0]         nxt;              // {found, bit index}

    // Lowest set bit of v at or above position 'from'; found flag in bit 4.
    function automatic logic [4:0] next_set(input logic [BIN_W-1:4] v,
                                            input logic [3:0] from);
        logic [4:0] r;
        r = 5'b0;
        for (int i = BIN_W-1; i >= 4; i--) begin
            if (v[i] && (i >= int'(from))) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction
`else
    localparam logic [3:0] K_LAST = 4'(BIN_W-1);
`endif

    // Single shared adder; operand b is the current bit weight or zero.
    bcd_add_4dig u_add (
        .a         (bcd_q),
        .b         (add_b),
        .sum       (add_sum),
        .carry_out (carry_unused)
    );

    // Next-state, operand capture and accumulation.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        k_d     = k_q;
        bcd_d   = bcd_q;
        add_b   = 16'h0000;
`ifdef BIN2BCD_SKIP_ZERO_EN
        nxt     = 5'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    din_d = din[BIN_W-1:4];
                    bcd_d = nib2bcd(din[3:0]);
`ifdef BIN2BCD_SKIP_ZERO_EN
                    nxt = next_set(din[BIN_W-1:4], 4'd4);
                    k_d = nxt[3:0];
                    state_d = nxt[4] ? ACC : DONE;
`else
                    k_d     = 4'd4;
                    state_d = ACC;
`endif
                end
            end
            ACC: begin
                if (din_q[k_q]) add_b = BCD_W[k_q];
                bcd_d = add_sum;
`ifdef BIN2BCD_SKIP_ZERO_EN
                nxt = next_set(din_q, 4'(k_q + 4'd1));
                k_d = nxt[3:0];
                if (!nxt[4]) state_d = DONE;
`else
                k_d = 4'(k_q + 4'd1);
                if (k_q == K_LAST) state_d = DONE;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            din_q   <= '0;
            k_q     <= 4'd0;
            bcd_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            k_q     <= k_d;
            bcd_q   <= bcd_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomized checks for bin2bcd_seq (either build of the macro).
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  din;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bcd;
    logic        busy;

    int n_vec;
    int n_err;

    bin2bcd_seq #(.BIN_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  din;
        logic [15:0] bcd;
        int          lat;
        int          lat_skip;
        string       name;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic convert(input logic [9:0] d, input logic [15:0] e,
                           input int lat, input string nm);
        int cnt;
        @(negedge clk);
        in_valid  = 1'b1;
        din       = d;
        out_ready = 1'b0;
        #1 check({nm, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = ~d;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 40);
        check({nm, " latency"}, 32'(cnt), 32'(lat));
        check({nm, " bcd"}, 32'(bcd), 32'(e));
        check({nm, " busy"}, 32'(busy), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({nm, " in_ready after"}, 32'(in_ready), 32'd1);
        check({nm, " out_valid after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] e;
        logic        acc_fire;
        logic        stable;
        int          cnt;
        int          n_acc;
        int          n_out;
        int          lat;

        n_vec = 0;
        n_err = 0;
        vt[0] = '{10'd0,    16'h0000, 7, 1, "din0"};
        vt[1] = '{10'd1023, 16'h1023, 7, 7, "din1023"};
        vt[2] = '{10'd255,  16'h0255, 7, 5, "din255"};
        vt[3] = '{10'd9,    16'h0009, 7, 1, "din9"};
        vt[4] = '{10'd15,   16'h0015, 7, 1, "din15"};
        vt[5] = '{10'd528,  16'h0528, 7, 3, "din528"};
        vt[6] = '{10'd512,  16'h0512, 7, 2, "din512"};
        vt[7] = '{10'd100,  16'h0100, 7, 3, "din100"};
        vt[8] = '{10'd999,  16'h0999, 7, 6, "din999"};
        vt[9] = '{10'd16,   16'h0016, 7, 2, "din16"};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset bcd", 32'(bcd), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
`ifdef BIN2BCD_SKIP_ZERO_EN
            lat = vt[i].lat_skip;
`else
            lat = vt[i].lat;
`endif
            convert(vt[i].din, vt[i].bcd, lat, vt[i].name);
        end

        // Result held under out_ready low, with competing in_valid
        @(negedge clk);
        in_valid = 1'b1;
        din      = 10'd1023;
        @(posedge clk);
        #1 din = 10'd5;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bcd !== 16'h1023 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check("stall stable", 32'(stable), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a conversion
        @(negedge clk);
        in_valid = 1'b1;
        din      = 10'd777;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst bcd", 32'(bcd), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst in_ready", 32'(in_ready), 32'd1);
`ifdef BIN2BCD_SKIP_ZERO_EN
        convert(10'd512, 16'h0512, 2, "post-rst 512");
`else
        convert(10'd512, 16'h0512, 7, "post-rst 512");
`endif

        // Random traffic with stalls against a reference model
        n_acc    = 0;
        n_out    = 0;
        acc_fire = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (!in_valid || acc_fire) begin
                in_valid = ($urandom_range(0, 3) != 0);
                din      = 10'($urandom_range(0, 1023));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc_fire = in_valid && in_ready;
            if (acc_fire) begin
                q.push_back(ref_bcd(int'(din)));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check("rand spurious output", 32'(bcd), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("rand bcd", 32'(bcd), 32'(e));
                end
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (out_valid) begin
                n_out++;
                if (q.size() == 0) begin
                    check("drain spurious output", 32'(bcd), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("drain bcd", 32'(bcd), 32'(e));
                end
            end
            @(negedge clk);
        end
        check("one output per accept", 32'(n_out), 32'(n_acc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
